// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
// Data-memory stage for the MIPS-lite MEM pipeline stage. Performs byte, half
// and word loads/stores on a big-endian byte-addressed memory, with sign or
// zero extension of loads, alignment/size/range checking, a configurable load
// latency behind a valid/ready handshake, a per-word "written since reset"
// flag and a saturating count of successful stores.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high
//   req_valid   request present
//   req_ready   unit can accept (high while the FSM is idle)
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_wdata   store data, byte/half taken from the LSBs
//   rsp_valid   one-cycle pulse per accepted request
//   rsp_err     qualifies rsp_valid: misaligned, illegal size or out of range
//   rsp_rdata   extended load data, 0 for stores and errors
//   wr_count    saturating count of successful stores
//   flag_addr   byte address for the written-flag query
//   flag_hit    word containing flag_addr written since reset
// ---------------------------------------------------------------------------
module data_mem_unit #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_BYTES = 4096,
   parameter int READ_LAT    = 1,
   parameter     INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic [31:0]       wr_count,
   input  logic [ADDR_W-1:0] flag_addr,
   output logic              flag_hit
);

   localparam int              DEPTH_WORDS = DEPTH_BYTES / 4;
   localparam int              IDX_W       = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W:0] LP_DEPTH    = (ADDR_W+1)'(DEPTH_BYTES);
   localparam logic [1:0]      LP_CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

   typedef enum logic {
      IDLE,
      BUSY
   } stateT;

   stateT             r_state;
   stateT             w_nextState;

   logic [31:0]       r_mem [DEPTH_WORDS];
   logic [DEPTH_WORDS-1:0] r_written;
   logic [1:0]        r_cnt;
   logic [31:0]       r_ldData;
   logic [31:0]       r_wrCount;
   logic              r_rspValid;
   logic              r_rspErr;
   logic [31:0]       r_rspRdata;

   logic              w_reqReady;
   logic              w_busyDone;
   logic              w_accept;
   logic              w_inRange;
   logic              w_misaligned;
   logic              w_err;
   logic              w_doStore;
   logic              w_doLoad;
   logic [IDX_W-1:0]  w_wordIdx;
   logic [31:0]       w_rdWord;
   logic [7:0]        w_ldByte;
   logic [15:0]       w_ldHalf;
   logic [31:0]       w_ldExt;
   logic [3:0]        w_be;
   logic [31:0]       w_wdataLanes;
   logic [IDX_W-1:0]  w_flagIdx;
   logic              w_flagInRange;

   // Request decode. Acceptance only depends on the registered state so the
   // handshake never loops back through the next-state logic.
   assign w_accept  = req_valid & (r_state == IDLE);
   assign w_inRange = ({1'b0, req_addr} < LP_DEPTH);
   assign w_wordIdx = req_addr[IDX_W+1:2];
   assign w_err     = w_misaligned | ~w_inRange;
   assign w_doStore = w_accept & req_we & ~w_err;
   assign w_doLoad  = w_accept & ~req_we & ~w_err;

   always_comb begin
      w_misaligned = 1'b0;
      unique case (req_size)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = req_addr[0];
         2'b10:   w_misaligned = |req_addr[1:0];
         default: w_misaligned = 1'b1;
      endcase
   end

   // Load lane selection and extension. Offset 0 is the most significant
   // byte of the word (big-endian lanes).
   assign w_rdWord = r_mem[w_wordIdx];

   always_comb begin
      w_ldByte = w_rdWord[7:0];
      unique case (req_addr[1:0])
         2'd0:    w_ldByte = w_rdWord[31:24];
         2'd1:    w_ldByte = w_rdWord[23:16];
         2'd2:    w_ldByte = w_rdWord[15:8];
         default: w_ldByte = w_rdWord[7:0];
      endcase
      w_ldHalf = req_addr[1] ? w_rdWord[15:0] : w_rdWord[31:16];
      w_ldExt  = 32'd0;
      unique case (req_size)
         2'b00:   w_ldExt = {{24{req_signed & w_ldByte[7]}}, w_ldByte};
         2'b01:   w_ldExt = {{16{req_signed & w_ldHalf[15]}}, w_ldHalf};
         2'b10:   w_ldExt = w_rdWord;
         default: w_ldExt = 32'd0;
      endcase
   end

   // Store lane enables and replicated store data, so every lane of the
   // word sees the right byte and only the enabled ones are written.
   always_comb begin
      w_be         = 4'b0000;
      w_wdataLanes = req_wdata;
      unique case (req_size)
         2'b00: begin
            w_be         = 4'b1000 >> req_addr[1:0];
            w_wdataLanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be         = req_addr[1] ? 4'b0011 : 4'b1100;
            w_wdataLanes = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            w_be         = 4'b1111;
            w_wdataLanes = req_wdata;
         end
         default: begin
            w_be         = 4'b0000;
            w_wdataLanes = req_wdata;
         end
      endcase
   end

   // Memory array: no reset, contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (w_doStore) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_wordIdx][i*8 +: 8] <= w_wdataLanes[i*8 +: 8];
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next state. Only a clean load with more than one cycle of latency
   // leaves IDLE; BUSY returns to IDLE when the down-counter runs out.
   always_comb begin
      w_nextState = r_state;
      w_reqReady  = 1'b0;
      w_busyDone  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_reqReady = 1'b1;
            if (w_doLoad && (READ_LAT > 1)) begin
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == 2'd0) begin
               w_nextState = IDLE;
               w_busyDone  = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Latency counter and captured load data. The word is sampled at the
   // accept edge, so later stores cannot change an in-flight load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= 2'd0;
         r_ldData <= 32'd0;
      end else if (w_doLoad) begin
         r_cnt    <= LP_CNT_INIT;
         r_ldData <= w_ldExt;
      end else if ((r_state == BUSY) && (r_cnt != 2'd0)) begin
         r_cnt <= r_cnt - 2'd1;
      end
   end

   // Response registers: cleared every cycle so err/rdata are 0 whenever
   // rsp_valid is low; an accept and a BUSY completion never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rspRdata <= 32'd0;
      end else begin
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rspRdata <= 32'd0;
         if (w_accept) begin
            if (w_err) begin
               r_rspValid <= 1'b1;
               r_rspErr   <= 1'b1;
            end else if (req_we) begin
               r_rspValid <= 1'b1;
            end else if (READ_LAT == 1) begin
               r_rspValid <= 1'b1;
               r_rspRdata <= w_ldExt;
            end
         end else if (w_busyDone) begin
            r_rspValid <= 1'b1;
            r_rspRdata <= r_ldData;
         end
      end
   end

   // Store bookkeeping: written flags and the saturating store counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_written <= '0;
         r_wrCount <= 32'd0;
      end else if (w_doStore) begin
         r_written[w_wordIdx] <= 1'b1;
         if (r_wrCount != 32'hFFFF_FFFF) begin
            r_wrCount <= r_wrCount + 32'd1;
         end
      end
   end

   assign w_flagIdx     = flag_addr[IDX_W+1:2];
   assign w_flagInRange = ({1'b0, flag_addr} < LP_DEPTH);
   assign flag_hit      = w_flagInRange & r_written[w_flagIdx];

   assign req_ready = w_reqReady;
   assign rsp_valid = r_rspValid;
   assign rsp_err   = r_rspErr;
   assign rsp_rdata = r_rspRdata;
   assign wr_count  = r_wrCount;

endmodule

// File: tb/tb_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_unit
// Drives two data_mem_unit instances (READ_LAT 1 and 3) and compares every
// response against a byte-array model of the memory, flags and store count.
// ---------------------------------------------------------------------------
module tb_data_mem_unit;

   logic        clk;
   logic        reset;
   logic        valid1, valid3;
   logic        we, sgn;
   logic [1:0]  size;
   logic [31:0] addr, wdata, flagAddr;

   logic        ready1, rspValid1, rspErr1, flagHit1;
   logic [31:0] rdata1, wrCount1;
   logic        ready3, rspValid3, rspErr3, flagHit3;
   logic [31:0] rdata3, wrCount3;

   int nCompared;
   int nMismatched;

   logic [7:0]  mMem   [2][4096];
   bit          mFlag  [2][1024];
   logic [31:0] mCount [2];
   int          mLat   [2];

   data_mem_unit #(.ADDR_W(32), .DEPTH_BYTES(4096), .READ_LAT(1), .INIT_FILE("")) u1 (
      .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
      .req_we(we), .req_size(size), .req_signed(sgn), .req_addr(addr),
      .req_wdata(wdata), .rsp_valid(rspValid1), .rsp_err(rspErr1),
      .rsp_rdata(rdata1), .wr_count(wrCount1), .flag_addr(flagAddr),
      .flag_hit(flagHit1)
   );

   data_mem_unit #(.ADDR_W(32), .DEPTH_BYTES(4096), .READ_LAT(3), .INIT_FILE("")) u3 (
      .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(ready3),
      .req_we(we), .req_size(size), .req_signed(sgn), .req_addr(addr),
      .req_wdata(wdata), .rsp_valid(rspValid3), .rsp_err(rspErr3),
      .rsp_rdata(rdata3), .wr_count(wrCount3), .flag_addr(flagAddr),
      .flag_hit(flagHit3)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so a stuck handshake can never hang the run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic getReady(input int s);
      return (s == 0) ? ready1 : ready3;
   endfunction
   function automatic logic getValid(input int s);
      return (s == 0) ? rspValid1 : rspValid3;
   endfunction
   function automatic logic getErr(input int s);
      return (s == 0) ? rspErr1 : rspErr3;
   endfunction
   function automatic logic [31:0] getRdata(input int s);
      return (s == 0) ? rdata1 : rdata3;
   endfunction
   function automatic logic [31:0] getCount(input int s);
      return (s == 0) ? wrCount1 : wrCount3;
   endfunction
   function automatic logic getFlag(input int s);
      return (s == 0) ? flagHit1 : flagHit3;
   endfunction

   // Single comparison point: counts, asserts, reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: big-endian byte array, computed straight from the
   // access rules, updated at the moment the request is accepted.
   task automatic modelReq(input int s, input logic mWe, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e, output logic [31:0] rd);
      int n;
      logic [31:0] v;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd4096);
      rd = 32'd0;
      if (!e) begin
         if (mWe) begin
            for (int k = 0; k < n; k++) begin
               mMem[s][int'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
            end
            mFlag[s][int'(a) / 4] = 1'b1;
            if (mCount[s] != 32'hFFFF_FFFF) mCount[s] = mCount[s] + 32'd1;
         end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) begin
               v = (v << 8) | 32'(mMem[s][int'(a) + k]);
            end
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
         end
      end
   endtask

   // One complete transaction on DUT s: present, wait for ready, accept,
   // wait the expected latency, compare the response and its pulse shape.
   task automatic applyStimulus(input int s, input logic aWe, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input string tag,
                                output logic oErr, output logic [31:0] oData);
      logic        eErr;
      logic [31:0] eData;
      int          n;
      int          expLat;
      @(negedge clk);
      we = aWe; size = sz; sgn = sg; addr = a; wdata = wd;
      if (s == 0) valid1 = 1'b1; else valid3 = 1'b1;
      n = 0;
      while (!getReady(s) && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_ready"}, 32'(getReady(s)), 32'd1);
      @(posedge clk);
      #1;
      valid1 = 1'b0;
      valid3 = 1'b0;
      modelReq(s, aWe, sz, sg, a, wd, eErr, eData);
      expLat = (!aWe && !eErr) ? mLat[s] - 1 : 0;
      n = 0;
      while (!getValid(s) && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_lat"},   32'(n), 32'(expLat));
      checkOutput({tag, "_err"},   32'(getErr(s)), 32'(eErr));
      checkOutput({tag, "_rdata"}, getRdata(s), eData);
      checkOutput({tag, "_count"}, getCount(s), mCount[s]);
      oErr  = getErr(s);
      oData = getRdata(s);
      @(posedge clk);
      #1;
      checkOutput({tag, "_pulse"},  32'(getValid(s)), 32'd0);
      checkOutput({tag, "_idle0"},  getRdata(s), 32'd0);
   endtask

   task automatic checkFlag(input int s, input logic [31:0] fa, input string tag);
      logic exp;
      @(negedge clk);
      flagAddr = fa;
      #1;
      exp = (fa < 32'd4096) ? mFlag[s][int'(fa) / 4] : 1'b0;
      checkOutput(tag, 32'(getFlag(s)), 32'(exp));
   endtask

   initial begin
      logic        e;
      logic [31:0] d;
      logic        eErr;
      logic [31:0] eData;
      logic        sawValid;
      logic [1:0]  rSz;
      logic [31:0] rAddr;

      nCompared   = 0;
      nMismatched = 0;
      mLat[0] = 1;
      mLat[1] = 3;
      mCount[0] = 32'd0;
      mCount[1] = 32'd0;
      valid1 = 1'b0; valid3 = 1'b0; we = 1'b0; sgn = 1'b0; size = 2'd0;
      addr = 32'd0; wdata = 32'd0; flagAddr = 32'd0;

      // Reset state.
      reset = 1'b1;
      #23;
      checkOutput("rst_ready1", 32'(ready1), 32'd1);
      checkOutput("rst_ready3", 32'(ready3), 32'd1);
      checkOutput("rst_valid1", 32'(rspValid1), 32'd0);
      checkOutput("rst_valid3", 32'(rspValid3), 32'd0);
      checkOutput("rst_rdata3", rdata3, 32'd0);
      checkOutput("rst_count3", wrCount3, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Word store, then byte/half loads from inside it.
      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "t2_sw", e, d);
      applyStimulus(1, 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, "t2_lb", e, d);
      checkOutput("t2_lb_const", d, 32'hFFFF_FFAD);
      applyStimulus(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, "t2_lhu", e, d);
      checkOutput("t2_lhu_const", d, 32'h0000_BEEF);

      // Byte store merges into the existing word.
      applyStimulus(1, 1'b1, 2'd0, 1'b0, 32'h13, 32'h1234_565A, "t3_sb", e, d);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t3_lw", e, d);
      checkOutput("t3_lw_const", d, 32'hDEAD_BE5A);
      checkOutput("t3_count_const", wrCount3, 32'd2);
      checkFlag(1, 32'h12, "t3_flag12");
      checkOutput("t3_flag12_const", 32'(flagHit3), 32'd1);
      checkFlag(1, 32'h20, "t3_flag20");

      // Misaligned store and load are rejected without side effects.
      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344, "t4_sw", e, d);
      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFF_FFFF, "t4_swmis", e, d);
      checkOutput("t4_swmis_err_const", 32'(e), 32'd1);
      checkOutput("t4_count_const", wrCount3, 32'd3);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, "t4_lw", e, d);
      checkOutput("t4_lw_const", d, 32'h1122_3344);
      applyStimulus(1, 1'b0, 2'd1, 1'b0, 32'h101, 32'd0, "t4_lhmis", e, d);
      checkOutput("t4_lhmis_err_const", 32'(e), 32'd1);

      // Out-of-range and illegal-size requests.
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'd4096, 32'd0, "t6_oor", e, d);
      checkOutput("t6_oor_err_const", 32'(e), 32'd1);
      applyStimulus(1, 1'b0, 2'd3, 1'b0, 32'h10, 32'd0, "t6_sz3", e, d);

      // READ_LAT=3 timing with a second request held valid throughout.
      @(negedge clk);
      we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h10; valid3 = 1'b1;
      @(posedge clk);
      #1;
      modelReq(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, eErr, eData);
      we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hCAFE_F00D;
      checkOutput("t5_e0_ready", 32'(ready3), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("t5_e1_ready", 32'(ready3), 32'd0);
      checkOutput("t5_e1_valid", 32'(rspValid3), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("t5_e2_ready", 32'(ready3), 32'd1);
      checkOutput("t5_e2_valid", 32'(rspValid3), 32'd1);
      checkOutput("t5_e2_rdata", rdata3, eData);
      checkOutput("t5_e2_const", rdata3, 32'hDEAD_BE5A);
      @(posedge clk);
      #1;
      valid3 = 1'b0;
      modelReq(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, eErr, eData);
      checkOutput("t5_e3_valid", 32'(rspValid3), 32'd1);
      checkOutput("t5_e3_err",   32'(rspErr3), 32'd0);
      checkOutput("t5_e3_count", wrCount3, mCount[1]);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "t5_lw20", e, d);

      // Reset one cycle after a READ_LAT=3 load is accepted.
      @(negedge clk);
      we = 1'b0; size = 2'd2; sgn = 1'b0; addr = 32'h10; valid3 = 1'b1;
      @(posedge clk);
      #1;
      valid3 = 1'b0;
      checkOutput("t1_busy", 32'(ready3), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      mCount[0] = 32'd0;
      mCount[1] = 32'd0;
      for (int i = 0; i < 1024; i++) begin
         mFlag[0][i] = 1'b0;
         mFlag[1][i] = 1'b0;
      end
      #2;
      checkOutput("t1_ready", 32'(ready3), 32'd1);
      checkOutput("t1_count", wrCount3, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         sawValid = sawValid | rspValid3;
      end
      checkOutput("t1_norsp", 32'(sawValid), 32'd0);
      checkFlag(1, 32'h12, "t1_flagclr");
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "t1_memkept", e, d);
      checkOutput("t1_memkept_const", d, 32'hDEAD_BE5A);

      // Randomized traffic on both latencies after a known word prefill.
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 64; w++) begin
            applyStimulus(s, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, "pre", e, d);
         end
         for (int i = 0; i < 80; i++) begin
            rSz   = 2'($urandom_range(0, 3));
            rAddr = ($urandom_range(0, 7) == 0) ? 32'(4096 + $urandom_range(0, 300))
                                                 : 32'($urandom_range(0, 255));
            applyStimulus(s, 1'($urandom_range(0, 1)), rSz, 1'($urandom_range(0, 1)),
                          rAddr, $urandom, "rnd", e, d);
         end
         checkFlag(s, 32'h0,    "rnd_flag0");
         checkFlag(s, 32'h40,   "rnd_flag40");
         checkFlag(s, 32'h104,  "rnd_flag104");
         checkFlag(s, 32'hFFC,  "rnd_flagFFC");
         checkFlag(s, 32'h1000, "rnd_flagOOR");
      end

      // Store counter saturation, preset just below the limit.
      @(negedge clk);
      force u1.r_wrCount = 32'hFFFF_FFFE;
      #1;
      release u1.r_wrCount;
      #1;
      mCount[0] = 32'hFFFF_FFFE;
      checkOutput("sat_preset", wrCount1, 32'hFFFF_FFFE);
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0102_0304, "sat_st1", e, d);
      checkOutput("sat_max", wrCount1, 32'hFFFF_FFFF);
      applyStimulus(0, 1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_0077, "sat_st2", e, d);
      checkOutput("sat_nowrap", wrCount1, 32'hFFFF_FFFF);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, "sat_lw", e, d);
      checkOutput("sat_lw_const", d, 32'h0177_0304);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
